vectored_interrupt_controller: RTL and testbench

- Parametrised successor to the two-source IRQ/FIQ interrupt path of the pipelined core.
- Accepts NUM_SRC interrupt lines with per-source enable and level/edge mode, and fixed priority (index 0 highest).
- Supports nesting through an in-service register and end-of-interrupt (EOI) handshake.
- Drains the pipeline for a configurable number of unstalled cycles, then issues a one-cycle take with vector PC. Sits beside the exception FSM; a synchronous exception (cancel) always wins.

---
 rtl/vectored_interrupt_controller.sv | 140 ++++++++++++++
 tb/tb_vectored_interrupt_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_interrupt_controller.sv
`default_nettype none
// ============================================================================
// vectored_interrupt_controller: prioritised, nestable interrupt entry with pipeline drain
// Revision: 1.0
// ============================================================================
module vectored_interrupt_controller #(
  parameter int          NUM_SRC      = 4,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] VEC_BASE     = 32'h18,
  parameter int          VEC_STRIDE   = 4,
  parameter int          ID_W         = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] enable,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic               global_en,
  input  logic               stall,
  input  logic               cancel,
  input  logic               eoi,
  input  logic [ID_W-1:0]    eoi_id,
  output logic               take,
  output logic [ID_W-1:0]    take_id,
  output logic [31:0]        vector_pc,
  output logic               stall_d,
  output logic               flush_d,
  output logic               busy,
  output logic [NUM_SRC-1:0] in_service
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAKE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] irq_sync, irq_prev, edge_pend, edge_pend_nxt;
  logic [NUM_SRC-1:0] pending, below_ceil, eligible, in_service_nxt;
  logic [ID_W-1:0]    cand_id, cand_nxt, best;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               any_elig;

  // A source is only eligible if no equal-or-higher priority source is in service.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    below_ceil = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      below_ceil[i] = ~seen & ~in_service[i];
      seen          = seen | in_service[i];
    end
    pending  = (edge_mode & edge_pend) | (~edge_mode & irq_sync);
    eligible = pending & enable & below_ceil & {NUM_SRC{global_en & ~cancel}};
    any_elig = |eligible;
    best     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) best = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand_id;
    cnt_nxt   = cnt;
    take      = 1'b0;
    flush_d   = 1'b0;
    stall_d   = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig && !stall) begin
          cand_nxt  = best;
          cnt_nxt   = CNT_INIT;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stall_d = 1'b1;
        if (!eligible[cand_id]) begin
          state_nxt = IDLE;
        end else begin
          // Pre-emption by a higher source keeps the drain progress already made.
          if (best < cand_id) cand_nxt = best;
          if (!stall) begin
            if (cnt == '0) state_nxt = TAKE;
            else           cnt_nxt   = cnt - CNT_W'(1);
          end
        end
      end
      TAKE: begin
        take      = 1'b1;
        flush_d   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // EOI clears first so a same-cycle take of the same ID wins; edge sets win over take clears.
  always_comb begin
    in_service_nxt = in_service;
    edge_pend_nxt  = edge_pend;
    if (eoi && ({1'b0, eoi_id} < (ID_W + 1)'(NUM_SRC))) in_service_nxt[eoi_id] = 1'b0;
    if (state == TAKE) begin
      in_service_nxt[cand_id] = 1'b1;
      edge_pend_nxt[cand_id]  = 1'b0;
    end
    edge_pend_nxt = edge_pend_nxt | (edge_mode & irq_sync & ~irq_prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cand_id    <= '0;
      cnt        <= '0;
      irq_sync   <= '0;
      irq_prev   <= '0;
      edge_pend  <= '0;
      in_service <= '0;
    end else begin
      state      <= state_nxt;
      cand_id    <= cand_nxt;
      cnt        <= cnt_nxt;
      irq_sync   <= irq_in;
      irq_prev   <= irq_sync;
      edge_pend  <= edge_pend_nxt;
      in_service <= in_service_nxt;
    end
  end

  assign take_id   = cand_id;
  assign vector_pc = VEC_BASE + (32'(cand_id) * 32'(VEC_STRIDE));
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vectored_interrupt_controller.sv
`default_nettype none
// Bench for vectored_interrupt_controller: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_vectored_interrupt_controller;
  localparam int N = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_in = '0, enable = '0, edge_mode = '0;
  logic         global_en = 1'b0, stall = 1'b0, cancel = 1'b0, eoi = 1'b0;
  logic [1:0]   eoi_id = '0;
  logic         take, stall_d, flush_d, busy;
  logic [1:0]   take_id;
  logic [31:0]  vector_pc;
  logic [N-1:0] in_service;

  vectored_interrupt_controller dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .enable(enable), .edge_mode(edge_mode),
    .global_en(global_en), .stall(stall), .cancel(cancel), .eoi(eoi), .eoi_id(eoi_id),
    .take(take), .take_id(take_id), .vector_pc(vector_pc), .stall_d(stall_d),
    .flush_d(flush_d), .busy(busy), .in_service(in_service)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: phase 0 idle, 1 draining, 2 taking.
  bit m_sync[N], m_prev[N], m_epend[N], m_insvc[N];
  int m_phase = 0, m_left = 0, m_cand = 0;

  always @(posedge clk) begin : model
    int ceil, best;
    bit elig[N];
    bit rise[N];
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_sync[i] = 0; m_prev[i] = 0; m_epend[i] = 0; m_insvc[i] = 0;
      end
      m_phase = 0; m_left = 0; m_cand = 0;
    end else begin
      ceil = N;
      for (int i = N - 1; i >= 0; i--) if (m_insvc[i]) ceil = i;
      best = -1;
      for (int i = N - 1; i >= 0; i--) begin
        elig[i] = (edge_mode[i] ? m_epend[i] : m_sync[i]) && enable[i] && global_en
                  && (i < ceil) && !cancel;
        if (elig[i]) best = i;
        rise[i] = m_sync[i] && !m_prev[i];
      end
      if (eoi && int'(eoi_id) < N) m_insvc[eoi_id] = 0;
      case (m_phase)
        0: if (best >= 0 && !stall) begin
          m_cand = best; m_left = D - 1; m_phase = 1;
        end
        1: if (!elig[m_cand]) m_phase = 0;
        else begin
          if (best >= 0 && best < m_cand) m_cand = best;
          if (!stall) begin
            if (m_left == 0) m_phase = 2;
            else m_left--;
          end
        end
        default: begin
          m_insvc[m_cand] = 1; m_epend[m_cand] = 0; m_phase = 0;
        end
      endcase
      for (int i = 0; i < N; i++) begin
        if (edge_mode[i] && rise[i]) m_epend[i] = 1;
        m_prev[i] = m_sync[i];
        m_sync[i] = irq_in[i];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_is;
    if (cmp_on) begin
      for (int i = 0; i < N; i++) exp_is[i] = m_insvc[i];
      chk("m_take", {31'd0, take}, {31'd0, m_phase == 2});
      chk("m_flush_d", {31'd0, flush_d}, {31'd0, m_phase == 2});
      chk("m_stall_d", {31'd0, stall_d}, {31'd0, m_phase == 1});
      chk("m_busy", {31'd0, busy}, {31'd0, m_phase != 0});
      chk("m_take_id", {30'd0, take_id}, 32'(m_cand));
      chk("m_vector_pc", vector_pc, 32'h18 + 32'(m_cand) * 4);
      chk("m_in_service", {28'd0, in_service}, {28'd0, exp_is});
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_stall_d(string nm);
    int k = 0;
    while (stall_d !== 1'b1 && k < 30) begin step(); k++; end
    checks++;
    if (stall_d !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout waiting for stall_d actual=%b required=1", nm, stall_d);
    end
  endtask

  task automatic wait_take(string nm);
    int k = 0;
    while (take !== 1'b1 && k < 30) begin step(); k++; end
    checks++;
    if (take !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout waiting for take actual=%b required=1", nm, take);
    end
  endtask

  initial begin
    enable    = 4'hF;
    global_en = 1'b1;
    step(2);
    cmp_on = 1'b1;
    chk("rst_take", {31'd0, take}, 32'd0);
    chk("rst_flush_d", {31'd0, flush_d}, 32'd0);
    chk("rst_stall_d", {31'd0, stall_d}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_take_id", {30'd0, take_id}, 32'd0);
    chk("rst_vector_pc", vector_pc, 32'h18);
    chk("rst_in_service", {28'd0, in_service}, 32'd0);
    reset = 1'b0;
    step(2);

    // Latency: level source 2 raised in cycle 0
    irq_in[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("lat_stall_d", {31'd0, stall_d}, {31'd0, (k >= 2 && k <= 4)});
      chk("lat_take", {31'd0, take}, {31'd0, k == 5});
      if (k == 5) begin
        chk("lat_take_id", {30'd0, take_id}, 32'd2);
        chk("lat_vector_pc", vector_pc, 32'h20);
      end
      if (k == 6) chk("lat_in_service", {28'd0, in_service}, 32'b0100);
    end

    // Nesting behind in-service source 2
    irq_in[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("nest_blocked_take", {31'd0, take}, 32'd0);
    end
    irq_in[0] = 1'b1;
    wait_take("nest_take0");
    chk("nest_take_id0", {30'd0, take_id}, 32'd0);
    chk("nest_vector_pc0", vector_pc, 32'h18);
    step();
    chk("nest_in_service", {28'd0, in_service}, 32'b0101);
    irq_in[0] = 1'b0;
    irq_in[2] = 1'b0;
    step(3);
    eoi = 1'b1; eoi_id = 2'd0;
    step();
    eoi = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("nest_still_blocked", {31'd0, take}, 32'd0);
    end
    chk("nest_after_eoi0", {28'd0, in_service}, 32'b0100);
    eoi = 1'b1; eoi_id = 2'd2;
    step();
    eoi = 1'b0;
    wait_take("nest_take3");
    chk("nest_take_id3", {30'd0, take_id}, 32'd3);
    chk("nest_vector_pc3", vector_pc, 32'h24);

    // Stall freezes the drain counter
    irq_in = '0;
    do_reset();
    step(2);
    irq_in[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stall_stall_d", {31'd0, stall_d}, {31'd0, (k >= 2 && k <= 6)});
      chk("stall_take", {31'd0, take}, {31'd0, k == 7});
      stall = (k == 3 || k == 4);
    end
    stall = 1'b0;

    // Edge capture survives a cancel
    irq_in = '0;
    edge_mode = 4'b0010;
    do_reset();
    step(2);
    irq_in[1] = 1'b1;
    step();
    irq_in[1] = 1'b0;
    wait_stall_d("edge_drain");
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_take", {31'd0, take}, 32'd0);
    wait_take("edge_retake");
    chk("edge_take_id", {30'd0, take_id}, 32'd1);
    chk("edge_vector_pc", vector_pc, 32'h1C);

    // Abort on disable
    edge_mode = '0;
    irq_in = '0;
    do_reset();
    irq_in[3] = 1'b1;
    wait_stall_d("dis_drain");
    enable[3] = 1'b0;
    step();
    chk("dis_busy", {31'd0, busy}, 32'd0);
    step(5);
    chk("dis_in_service", {28'd0, in_service}, 32'd0);
    enable = 4'hF;
    irq_in = '0;

    // Reset mid-drain drops a pending edge
    edge_mode = 4'b0010;
    do_reset();
    step(2);
    irq_in[1] = 1'b1;
    step();
    irq_in[1] = 1'b0;
    wait_stall_d("rst_drain");
    reset = 1'b1;
    step();
    chk("mid_rst_stall_d", {31'd0, stall_d}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_take_id", {30'd0, take_id}, 32'd0);
    chk("mid_rst_vector_pc", vector_pc, 32'h18);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("mid_rst_no_take", {31'd0, take}, 32'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
      if ($urandom_range(49) == 0) enable = 4'($urandom) | 4'($urandom);
      if (c % 300 == 0) edge_mode = 4'($urandom);
      global_en = ($urandom_range(15) != 0);
      stall     = ($urandom_range(3) == 0);
      cancel    = ($urandom_range(19) == 0);
      eoi       = ($urandom_range(5) == 0);
      eoi_id    = 2'($urandom);
      reset     = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
